// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: pixel width, write-scheduler state encoding,
// and default VGA 640x480 timing constants used by the engine and scan-out.
package fb_pkg;

  localparam int FB_PIX_W = 4;

  localparam int FB_H_VISIBLE = 640;
  localparam int FB_H_FRONT   = 16;
  localparam int FB_H_SYNC    = 96;
  localparam int FB_H_BACK    = 48;
  localparam int FB_V_VISIBLE = 480;
  localparam int FB_V_FRONT   = 10;
  localparam int FB_V_SYNC    = 2;
  localparam int FB_V_BACK    = 33;

  typedef enum logic [2:0] {
    FB_IDLE     = 3'd0,
    FB_ENTER    = 3'd1,
    FB_SELECT   = 3'd2,
    FB_PTR      = 3'd3,
    FB_ISSUE    = 3'd4,
    FB_WAIT_ACK = 3'd5,
    FB_EXIT     = 3'd6
  } fb_state_e;

  typedef struct packed {
    logic                sof;
    logic [FB_PIX_W-1:0] gray;
  } fb_pix_t;

endpackage

// File: rtl/fb_pixel_fifo.sv
// Synchronous pixel FIFO with occupancy output. The head is read combinationally,
// so a pushed entry is visible one cycle after the push.
module fb_pixel_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 5,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign level   = count;
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Buffers engine pixels and writes them to the framebuffer only inside the
// v-blank window, so RAM writes never collide with VGA scan-out reads.
module fb_write_scheduler import fb_pkg::*; #(
  parameter  int FIFO_DEPTH    = 16,
  parameter  int WINDOW_CYCLES = 34000,
  parameter  int GUARD_CYCLES  = 64,
  parameter  int ACK_TIMEOUT   = 31,
  localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                v_sync,
  input  logic                pix_valid,
  input  logic                pix_sof,
  input  logic [FB_PIX_W-1:0] pix_gray,
  output logic                pix_ready,
  output logic                write_mode,
  output logic                reset_write_ptr,
  output logic                write_data,
  output logic [FB_PIX_W-1:0] write_data_in,
  input  logic                wrote_data,
  output logic [LVL_W-1:0]    fifo_level,
  output logic                ack_error,
  output fb_state_e           dbg_state
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
  localparam int TMO_W = $clog2(2 * ACK_TIMEOUT + 1);
  localparam logic [WIN_W-1:0] WIN_LOAD   = WIN_W'(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0] GUARD_V    = WIN_W'(GUARD_CYCLES);
  localparam logic [TMO_W-1:0] ENTER_LAST = TMO_W'(2 * ACK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] ACK_LAST   = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] EXIT_LAST  = TMO_W'(1);

  fb_state_e                state;
  fb_state_e                state_next;
  logic [TMO_W-1:0]         wait_ctr;
  logic [WIN_W-1:0]         win_ctr;
  logic                     win_open;
  logic                     vs_q;
  logic                     vs_rise;
  logic                     set_err;
  logic                     write_mode_q;
  logic [FB_PIX_W-1:0]      data_q;
  fb_pix_t                  head;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     push;

  assign pix_ready = ~fifo_full;
  assign push      = pix_valid & pix_ready;

  fb_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fb_pix_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({pix_sof, pix_gray}),
    .pop       (write_data),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  // Window counter reloads on every v_sync rise, even mid-transfer.
  assign vs_rise  = v_sync & ~vs_q;
  assign win_open = (win_ctr > GUARD_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b0;
      win_ctr <= '0;
    end else begin
      vs_q <= v_sync;
      if (vs_rise)              win_ctr <= WIN_LOAD;
      else if (win_ctr != '0)   win_ctr <= win_ctr - 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    set_err    = 1'b0;
    case (state)
      FB_IDLE:     if (vs_rise && !fifo_empty) state_next = FB_ENTER;
      FB_ENTER: begin
        if (wrote_data) state_next = FB_SELECT;
        else if (wait_ctr == ENTER_LAST) begin
          state_next = FB_EXIT;
          set_err    = 1'b1;
        end
      end
      FB_SELECT: begin
        if (fifo_empty || !win_open) state_next = FB_EXIT;
        else if (head.sof)           state_next = FB_PTR;
        else                         state_next = FB_ISSUE;
      end
      FB_PTR:      state_next = FB_ISSUE;
      FB_ISSUE:    state_next = FB_WAIT_ACK;
      FB_WAIT_ACK: begin
        if (wrote_data) state_next = FB_SELECT;
        else if (wait_ctr == ACK_LAST) begin
          state_next = FB_EXIT;
          set_err    = 1'b1;
        end
      end
      FB_EXIT:     if (wait_ctr == EXIT_LAST) state_next = FB_IDLE;
      default:     state_next = FB_IDLE;
    endcase
  end

  // wait_ctr counts cycles spent in the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FB_IDLE;
      wait_ctr     <= '0;
      write_mode_q <= 1'b0;
      ack_error    <= 1'b0;
      data_q       <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) wait_ctr <= '0;
      else if (wait_ctr != '1) wait_ctr <= wait_ctr + 1'b1;
      write_mode_q <= state_next inside {FB_ENTER, FB_SELECT, FB_PTR, FB_ISSUE, FB_WAIT_ACK};
      if (set_err) ack_error <= 1'b1;
      if (state == FB_ISSUE) data_q <= head.gray;
    end
  end

  assign write_mode      = write_mode_q;
  assign write_data      = (state == FB_ISSUE);
  assign reset_write_ptr = (state == FB_PTR);
  assign write_data_in   = write_data ? head.gray : data_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler with a stub framebuffer that acks
// write-mode entry and pixel writes; strobes are scored against an expected queue.
module tb_fb_write_scheduler;
  import fb_pkg::*;

  localparam int DEPTH = 16;
  localparam int WIN   = 100;
  localparam int GUARD = 64;
  localparam int TMO   = 31;
  localparam int LVL_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             v_sync = 1'b0;
  logic             pix_valid = 1'b0;
  logic             pix_sof = 1'b0;
  logic [3:0]       pix_gray = 4'h0;
  logic             wrote_data = 1'b0;
  logic             pix_ready;
  logic             write_mode;
  logic             reset_write_ptr;
  logic             write_data;
  logic [3:0]       write_data_in;
  logic [LVL_W-1:0] fifo_level;
  logic             ack_error;
  fb_state_e        dbg_state;

  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  bit   pix_ack_on = 1'b1;
  int   enter_dly = 4;
  int   pix_dly = 1;
  int   ack_cnt = 0;
  logic wm_prev = 1'b0;

  typedef struct {
    logic             valid;
    logic             sof;
    logic [3:0]       gray;
    logic [LVL_W-1:0] exp_level;
    logic             exp_ready;
  } vec_t;
  vec_t vecs[17];

  fb_write_scheduler #(
    .FIFO_DEPTH    (DEPTH),
    .WINDOW_CYCLES (WIN),
    .GUARD_CYCLES  (GUARD),
    .ACK_TIMEOUT   (TMO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .v_sync          (v_sync),
    .pix_valid       (pix_valid),
    .pix_sof         (pix_sof),
    .pix_gray        (pix_gray),
    .pix_ready       (pix_ready),
    .write_mode      (write_mode),
    .reset_write_ptr (reset_write_ptr),
    .write_data      (write_data),
    .write_data_in   (write_data_in),
    .wrote_data      (wrote_data),
    .fifo_level      (fifo_level),
    .ack_error       (ack_error),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stub framebuffer: acks write-mode entry after enter_dly cycles and each
  // write strobe after pix_dly cycles (unless pixel acks are disabled).
  always @(posedge clk) begin
    #1;
    wrote_data = 1'b0;
    if (!rst_n) ack_cnt = 0;
    else begin
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) wrote_data = 1'b1;
      end
      if (write_mode && !wm_prev)         ack_cnt = enter_dly;
      else if (write_data && pix_ack_on)  ack_cnt = pix_dly;
    end
    wm_prev = write_mode;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every pointer rewind (0x10) and write strobe ({0,gray}) in order.
  always @(negedge clk) begin : mon
    logic [4:0] ev;
    if (rst_n && (reset_write_ptr || write_data)) begin
      ev = reset_write_ptr ? 5'h10 : {1'b0, write_data_in};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got 0x%0h expected none", ev);
      end else begin
        chk("strobe_order", ev, exp_q.pop_front());
      end
      chk("wm_during_strobe", write_mode, 1);
    end
  end

  // driver tasks
  task automatic push_pix(input logic sof, input logic [3:0] g);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_gray  = g;
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic pulse_vsync();
    v_sync = 1'b1;
    repeat (3) @(negedge clk);
    v_sync = 1'b0;
  endtask

  task automatic wait_wm(input logic val, input int max, input string name);
    int n = 0;
    while (write_mode !== val && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, write_mode, val);
  endtask

  task automatic wait_strobe(input int max, input string name);
    int n = 0;
    while (write_data !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, write_data, 1);
  endtask

  task automatic wait_state(input fb_state_e s, input int max, input string name);
    int n = 0;
    while (dbg_state !== s && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, dbg_state, s);
  endtask

  task automatic finish_window(input string tag, input logic [LVL_W-1:0] exp_lvl);
    wait_wm(1'b1, 10, {tag, "_wm_rise"});
    wait_wm(1'b0, 300, {tag, "_wm_fall"});
    chk({tag, "_level"}, fifo_level, exp_lvl);
    chk({tag, "_drained"}, exp_q.size(), 0);
    repeat (2) @(negedge clk);
    chk({tag, "_idle"}, dbg_state, FB_IDLE);
  endtask

  initial begin
    int n;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_write_mode", write_mode, 0);
    chk("rst_write_ptr", reset_write_ptr, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_data_in", write_data_in, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ack_error", ack_error, 0);
    chk("rst_state", dbg_state, FB_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // five pixels, first with sof: rewind then gray 1..5
    exp_q.push_back(5'h10);
    for (int g = 1; g <= 5; g++) exp_q.push_back({1'b0, 4'(g)});
    push_pix(1'b1, 4'd1);
    for (int g = 2; g <= 5; g++) push_pix(1'b0, 4'(g));
    chk("t1_level_pre", fifo_level, 5);
    chk("t1_wm_idle", write_mode, 0);
    pulse_vsync();
    finish_window("t1", 0);

    // fill the FIFO with v_sync low (table-driven)
    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, (i == 0), 4'(i), LVL_W'(i + 1), (i < 15)};
    vecs[16] = '{1'b1, 1'b0, 4'hf, LVL_W'(16), 1'b0};
    for (int i = 0; i < 17; i++) begin
      pix_valid = vecs[i].valid;
      pix_sof   = vecs[i].sof;
      pix_gray  = vecs[i].gray;
      @(negedge clk);
      chk($sformatf("fill_level_%0d", i), fifo_level, vecs[i].exp_level);
      chk($sformatf("fill_ready_%0d", i), pix_ready, vecs[i].exp_ready);
      chk($sformatf("fill_wm_%0d", i), write_mode, 0);
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    repeat (5) @(negedge clk);
    chk("fill_hold_level", fifo_level, 16);
    chk("fill_hold_wm", write_mode, 0);

    // short window: 10 pixels fit before win_ctr <= GUARD, 6 carry over
    exp_q.push_back(5'h10);
    for (int g = 0; g < 10; g++) exp_q.push_back({1'b0, 4'(g)});
    pulse_vsync();
    finish_window("t3a", 6);
    for (int g = 10; g < 16; g++) exp_q.push_back({1'b0, 4'(g)});
    pulse_vsync();
    finish_window("t3b", 0);

    // pixel ack never arrives: error after ACK_TIMEOUT cycles in WAIT_ACK
    pix_ack_on = 1'b0;
    exp_q.push_back({1'b0, 4'd7});
    push_pix(1'b0, 4'd7);
    push_pix(1'b0, 4'd8);
    pulse_vsync();
    wait_strobe(50, "t4_strobe");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_error && n < 100);
    chk("t4_tmo_cycles", n, TMO + 1);
    chk("t4_ack_error", ack_error, 1);
    chk("t4_wm_low", write_mode, 0);
    repeat (2) @(negedge clk);
    chk("t4_idle", dbg_state, FB_IDLE);
    chk("t4_level", fifo_level, 1);
    chk("t4_drained", exp_q.size(), 0);

    // async reset while waiting for an ack
    exp_q.push_back({1'b0, 4'd8});
    for (int g = 1; g <= 3; g++) push_pix(1'b0, 4'(g));
    pulse_vsync();
    wait_strobe(50, "t5_strobe");
    @(negedge clk);
    chk("t5_in_wait", dbg_state, FB_WAIT_ACK);
    chk("t5_wm_high", write_mode, 1);
    chk("t5_level_pre", fifo_level, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_wm", write_mode, 0);
    chk("t5_wd", write_data, 0);
    chk("t5_ptr", reset_write_ptr, 0);
    chk("t5_level", fifo_level, 0);
    chk("t5_ack_error", ack_error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pix_ack_on = 1'b1;
    chk("t5_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    // push and pop in the same cycle at level 3
    for (int g = 9; g <= 12; g++) exp_q.push_back({1'b0, 4'(g)});
    for (int g = 9; g <= 11; g++) push_pix(1'b0, 4'(g));
    chk("t6_level_pre", fifo_level, 3);
    pulse_vsync();
    wait_state(FB_ISSUE, 50, "t6_issue");
    chk("t6_level_issue", fifo_level, 3);
    pix_valid = 1'b1;
    pix_gray  = 4'd12;
    @(negedge clk);
    pix_valid = 1'b0;
    chk("t6_level_pushpop", fifo_level, 3);
    wait_wm(1'b0, 300, "t6_wm_fall");
    chk("t6_level", fifo_level, 0);
    chk("t6_drained", exp_q.size(), 0);
    chk("final_ack_error", ack_error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
